pc_sequencer: RTL and testbench

Instruction-sequencing controller for the 16-bit program counter. It runs the fetch/execute loop: it issues a fetch handshake for the current PC, waits for the execute stage to finish, and then drives the program counter's `increment`, `jump_set` and `jumpcount` inputs to select sequential flow, a branch, a call or a return. It sits between the PC, instruction memory and the execute stage. The optional return-address stack makes it the single owner of every PC update.

---
 rtl/pc_sequencer_if.sv | 32 +++
 rtl/pc_sequencer.sv | 126 ++++++++++++
 tb/tb_pc_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Sequencer-facing bundle: run control, fetch handshake, execute decision and PC drive signals.
// master is the sequencer side, slave is the PC / memory / execute side.
interface pc_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              run;
  logic [ADDR_W-1:0] pc;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ack;
  logic              exec_done;
  logic              halt;
  logic              br_taken;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] br_target;
  logic              increment;
  logic              jump_set;
  logic [ADDR_W-1:0] jumpcount;
  logic              busy;
  logic              fault;

  modport master (
    input  run, pc, fetch_ack, exec_done, halt, br_taken, call, ret, br_target,
    output fetch_req, fetch_addr, increment, jump_set, jumpcount, busy, fault
  );

  modport slave (
    output run, pc, fetch_ack, exec_done, halt, br_taken, call, ret, br_target,
    input  fetch_req, fetch_addr, increment, jump_set, jumpcount, busy, fault
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer owning PC updates: 3 cycles per instruction minimum, stalls in FETCH
// until fetch_ack and in EXEC until exec_done. Define RETURN_STACK_EN to build the return-address stack.
module pc_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic           clock,
  input  logic           reset,
  pc_sequencer_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_UPDATE, S_FAULT} state_t;

  state_t            state, state_nxt;
  logic              increment_q, jump_set_q, fault_q;
  logic              increment_nxt, jump_set_nxt, fault_nxt;
  logic [ADDR_W-1:0] jumpcount_q, jumpcount_nxt;

`ifdef RETURN_STACK_EN
  localparam int IDX_W = $clog2(RAS_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [SP_W-1:0]   sp;
  logic [IDX_W-1:0]  top_idx;
  logic              stack_full, stack_empty, push, pop;

  assign top_idx     = IDX_W'(sp - SP_W'(1));
  assign stack_full  = (sp == SP_W'(RAS_DEPTH));
  assign stack_empty = (sp == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      sp <= '0;
    end else if (push) begin
      ras[IDX_W'(sp)] <= bus.pc + ADDR_W'(1);
      sp              <= sp + SP_W'(1);
    end else if (pop) begin
      sp <= sp - SP_W'(1);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = bus.ret ^ (RAS_DEPTH == 0);
`endif

  always_comb begin
    state_nxt     = state;
    increment_nxt = 1'b0;
    jump_set_nxt  = 1'b0;
    jumpcount_nxt = jumpcount_q;
    fault_nxt     = fault_q;
`ifdef RETURN_STACK_EN
    push          = 1'b0;
    pop           = 1'b0;
`endif
    unique case (state)
      S_IDLE:   if (bus.run) state_nxt = S_FETCH;
      S_FETCH:  if (bus.fetch_ack) state_nxt = S_EXEC;
      S_EXEC: begin
        if (bus.exec_done) begin
          state_nxt = S_UPDATE;
          if (bus.halt) begin
            state_nxt = S_IDLE;
`ifdef RETURN_STACK_EN
          end else if (bus.ret) begin
            // A stack error suppresses the pop and the PC update entirely.
            if (stack_empty) begin
              fault_nxt = 1'b1;
              state_nxt = S_FAULT;
            end else begin
              pop           = 1'b1;
              jump_set_nxt  = 1'b1;
              jumpcount_nxt = ras[top_idx];
            end
          end else if (bus.call) begin
            if (stack_full) begin
              fault_nxt = 1'b1;
              state_nxt = S_FAULT;
            end else begin
              push          = 1'b1;
              jump_set_nxt  = 1'b1;
              jumpcount_nxt = bus.br_target;
            end
`else
          end else if (bus.call) begin
            jump_set_nxt  = 1'b1;
            jumpcount_nxt = bus.br_target;
`endif
          end else if (bus.br_taken) begin
            jump_set_nxt  = 1'b1;
            jumpcount_nxt = bus.br_target;
          end else begin
            increment_nxt = 1'b1;
          end
        end
      end
      S_UPDATE: state_nxt = S_FETCH;
      S_FAULT:  state_nxt = S_FAULT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      increment_q <= 1'b0;
      jump_set_q  <= 1'b0;
      jumpcount_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      state       <= state_nxt;
      increment_q <= increment_nxt;
      jump_set_q  <= jump_set_nxt;
      jumpcount_q <= jumpcount_nxt;
      fault_q     <= fault_nxt;
    end
  end

  assign bus.fetch_req  = (state == S_FETCH);
  assign bus.fetch_addr = bus.pc;
  assign bus.busy       = (state == S_FETCH) || (state == S_EXEC) || (state == S_UPDATE);
  assign bus.increment  = increment_q;
  assign bus.jump_set   = jump_set_q;
  assign bus.jumpcount  = jumpcount_q;
  assign bus.fault      = fault_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: behavioural PC plus an instruction-level reference model (queue stack).
module tb_pc_sequencer;
  localparam int ADDR_W    = 16;
  localparam int RAS_DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_val = 16'h0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_pc = 16'h0;
  logic [15:0] exp_jc = 16'h0;
`ifdef RETURN_STACK_EN
  logic [15:0] stk [$];
`endif

  pc_sequencer_if #(.ADDR_W(ADDR_W)) sb ();

  pc_sequencer #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (sb.master)
  );

  always #5 clock = ~clock;

  // The program counter the sequencer steers
  always @(posedge clock) begin
    if (pc_load)           sb.pc <= pc_load_val;
    else if (sb.jump_set)  sb.pc <= sb.jumpcount;
    else if (sb.increment) sb.pc <= sb.pc + 16'd1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run still active at 2000000, required to finish earlier");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [4:0] flags();
    return {sb.fetch_req, sb.busy, sb.increment, sb.jump_set, sb.fault};
  endfunction

  task automatic clear_inputs();
    sb.run = 1'b0; sb.fetch_ack = 1'b0; sb.exec_done = 1'b0; sb.halt = 1'b0;
    sb.br_taken = 1'b0; sb.call = 1'b0; sb.ret = 1'b0; sb.br_target = 16'h0;
  endtask

  task automatic noise_decisions();
    sb.halt      = 1'($urandom_range(0, 1));
    sb.ret       = 1'($urandom_range(0, 1));
    sb.call      = 1'($urandom_range(0, 1));
    sb.br_taken  = 1'($urandom_range(0, 1));
    sb.br_target = 16'($urandom);
  endtask

  task automatic do_reset(input logic [15:0] p);
    reset = 1'b1; pc_load = 1'b1; pc_load_val = p;
    noise_decisions();
    sb.run = 1'($urandom_range(0, 1)); sb.fetch_ack = 1'($urandom_range(0, 1));
    sb.exec_done = 1'($urandom_range(0, 1));
    step();
    step();
    reset = 1'b0; pc_load = 1'b0;
    clear_inputs();
    exp_pc = p;
    exp_jc = 16'h0;
`ifdef RETURN_STACK_EN
    stk.delete();
`endif
  endtask

  task automatic start(input logic [15:0] p);
    pc_load = 1'b1; pc_load_val = p; sb.run = 1'b1;
    step();
    pc_load = 1'b0; sb.run = 1'b0;
    exp_pc = p;
    vectors++;
    if ({flags(), sb.fetch_addr} !== {5'b11000, p}) begin
      miscompares++;
      $display("FAIL start: flags=%b addr=%h, expected flags=11000 addr=%h", flags(), sb.fetch_addr, p);
    end
  endtask

  // kind: 0 sequential, 1 jump, 2 halt, 3 stack fault
  task automatic do_instr(input int ack_dly, input int exe_dly, input logic h, input logic r,
                          input logic c, input logic b, input logic [15:0] tgt, output int kind);
    logic [4:0] ef;
`ifdef RETURN_STACK_EN
    logic [15:0] nxt;
`endif
    vectors++;
    if ({flags(), sb.fetch_addr} !== {5'b11000, exp_pc}) begin
      miscompares++;
      $display("FAIL fetch_entry: flags=%b addr=%h, expected flags=11000 addr=%h", flags(), sb.fetch_addr, exp_pc);
    end
    for (int i = 0; i < ack_dly; i++) begin
      sb.fetch_ack = 1'b0; noise_decisions();
      sb.exec_done = 1'($urandom_range(0, 1)); sb.run = 1'($urandom_range(0, 1));
      step();
      vectors++;
      if (flags() !== 5'b11000) begin
        miscompares++;
        $display("FAIL fetch_wait: flags=%b, expected 11000", flags());
      end
    end
    sb.fetch_ack = 1'b1; noise_decisions();
    sb.exec_done = 1'($urandom_range(0, 1)); sb.run = 1'($urandom_range(0, 1));
    step();
    vectors++;
    if (flags() !== 5'b01000) begin
      miscompares++;
      $display("FAIL exec_entry: flags=%b, expected 01000", flags());
    end
    for (int i = 0; i < exe_dly; i++) begin
      sb.exec_done = 1'b0; noise_decisions();
      sb.fetch_ack = 1'($urandom_range(0, 1)); sb.run = 1'($urandom_range(0, 1));
      step();
      vectors++;
      if (flags() !== 5'b01000) begin
        miscompares++;
        $display("FAIL exec_wait: flags=%b, expected 01000", flags());
      end
    end
    sb.exec_done = 1'b1; sb.halt = h; sb.ret = r; sb.call = c; sb.br_taken = b;
    sb.br_target = tgt; sb.run = 1'b0; sb.fetch_ack = 1'($urandom_range(0, 1));
    step();
    noise_decisions();
    sb.exec_done = 1'($urandom_range(0, 1)); sb.fetch_ack = 1'($urandom_range(0, 1)); sb.run = 1'b0;

    kind = 0;
    if (h) kind = 2;
`ifdef RETURN_STACK_EN
    else if (r) begin
      if (stk.size() == 0) kind = 3;
      else begin kind = 1; exp_jc = stk.pop_back(); end
    end else if (c) begin
      if (stk.size() == RAS_DEPTH) kind = 3;
      else begin nxt = exp_pc + 16'd1; stk.push_back(nxt); kind = 1; exp_jc = tgt; end
    end
`else
    else if (c) begin kind = 1; exp_jc = tgt; end
`endif
    else if (b) begin kind = 1; exp_jc = tgt; end

    case (kind)
      0:       ef = 5'b01100;
      1:       ef = 5'b01010;
      2:       ef = 5'b00000;
      default: ef = 5'b00001;
    endcase
    vectors++;
    if ({flags(), sb.jumpcount} !== {ef, exp_jc}) begin
      miscompares++;
      $display("FAIL update: flags=%b jumpcount=%h, expected flags=%b jumpcount=%h", flags(), sb.jumpcount, ef, exp_jc);
    end
    step();
    if (kind == 0) exp_pc = exp_pc + 16'd1;
    else if (kind == 1) exp_pc = exp_jc;
    ef = (kind < 2) ? 5'b11000 : ((kind == 2) ? 5'b00000 : 5'b00001);
    vectors++;
    if ({flags(), sb.jumpcount, sb.fetch_addr} !== {ef, exp_jc, exp_pc}) begin
      miscompares++;
      $display("FAIL after_update: flags=%b jumpcount=%h addr=%h, expected flags=%b jumpcount=%h addr=%h",
               flags(), sb.jumpcount, sb.fetch_addr, ef, exp_jc, exp_pc);
    end
  endtask

  task automatic fault_hold();
    for (int i = 0; i < 3; i++) begin
      sb.run = 1'b1; sb.fetch_ack = 1'($urandom_range(0, 1));
      sb.exec_done = 1'($urandom_range(0, 1)); noise_decisions();
      step();
      vectors++;
      if ({flags(), sb.fetch_addr} !== {5'b00001, exp_pc}) begin
        miscompares++;
        $display("FAIL fault_hold: flags=%b addr=%h, expected flags=00001 addr=%h", flags(), sb.fetch_addr, exp_pc);
      end
    end
    sb.run = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] p;
    for (int k = 0; k < 2; k++) begin
      p = 16'($urandom);
      do_reset(p);
      vectors++;
      if ({flags(), sb.jumpcount, sb.fetch_addr} !== {5'b00000, 16'h0000, p}) begin
        miscompares++;
        $display("FAIL reset_state: flags=%b jumpcount=%h addr=%h, expected flags=00000 jumpcount=0000 addr=%h",
                 flags(), sb.jumpcount, sb.fetch_addr, p);
      end
    end
  endtask

  task automatic test_sequential();
    int k;
    do_reset(16'h0000);
    start(16'h0000);
    for (int i = 0; i < 3; i++) do_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'($urandom), k);
  endtask

  task automatic test_branch();
    int k;
    do_reset(16'($urandom));
    start(16'h0040);
    do_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, k);
    do_instr(1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5555, k);
  endtask

  task automatic test_call_ret();
    int k;
    do_reset(16'h0);
    start(16'h0010);
    do_instr(0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0200, k);
    do_instr(2, 0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0999, k);
    do_reset(16'h0);
    start(16'hFFFF);
    do_instr(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0ABC, k);
    do_instr(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0123, k);
  endtask

  task automatic test_stack_limits();
    int k;
    do_reset(16'h0);
    start(16'h0100);
    for (int i = 0; i < 5; i++) begin
      do_instr(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1000 + 16'(i * 16), k);
      if (k == 3) fault_hold();
    end
    do_reset(16'h0);
    start(16'h0040);
    do_instr(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0077, k);
    if (k == 3) fault_hold();
  endtask

  task automatic test_priority();
    int k;
    do_reset(16'h0);
    start(16'h0300);
    do_instr(0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0888, k);
    start(16'h0300);
    do_instr(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0400, k);
    do_instr(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0777, k);
  endtask

  task automatic test_reset_mid();
    do_reset(16'h0);
    start(16'h0500);
    sb.fetch_ack = 1'b0;
    step();
    reset = 1'b1; sb.fetch_ack = 1'b0;
    step();
    reset = 1'b0;
    exp_jc = 16'h0;
`ifdef RETURN_STACK_EN
    stk.delete();
`endif
    vectors++;
    if ({flags(), sb.jumpcount} !== {5'b00000, 16'h0000}) begin
      miscompares++;
      $display("FAIL reset_in_fetch: flags=%b jumpcount=%h, expected flags=00000 jumpcount=0000", flags(), sb.jumpcount);
    end
    // Reset landing on the decision cycle must drop the pending jump.
    start(16'h0600);
    sb.fetch_ack = 1'b1;
    step();
    sb.fetch_ack = 1'b0; sb.exec_done = 1'b1; sb.br_taken = 1'b1; sb.br_target = 16'h0ACE; reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({flags(), sb.jumpcount} !== {5'b00000, 16'h0000}) begin
        miscompares++;
        $display("FAIL reset_drop: flags=%b jumpcount=%h, expected flags=00000 jumpcount=0000", flags(), sb.jumpcount);
      end
      sb.run = 1'b0; sb.fetch_ack = 1'($urandom_range(0, 1));
      sb.exec_done = 1'($urandom_range(0, 1)); noise_decisions();
      step();
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    int k;
    logic h, r, c, b;
    do_reset(16'($urandom));
    start(16'($urandom));
    for (int n = 0; n < 120; n++) begin
      h = ($urandom_range(0, 11) == 0);
      r = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 2) == 0);
      do_instr($urandom_range(0, 3) == 0 ? 2 : 0, $urandom_range(0, 3) == 0 ? 1 : 0,
               h, r, c, b, 16'($urandom), k);
      if (k == 2) begin
        start(($urandom_range(0, 1) == 0) ? exp_pc : 16'($urandom));
      end else if (k == 3) begin
        fault_hold();
        do_reset(16'($urandom));
        start(16'($urandom));
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_sequential();
    test_branch();
    test_call_ret();
    test_stack_limits();
    test_priority();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
